// File: rtl/delay_scheduler.sv
// Programmable interval timer: counts a requested number of TICK_CYCLES-long units
// and pulses done once on completion, with pause, cancel, restart and progress readback.
module delay_scheduler #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int DUR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DUR_W-1:0] duration,
  input  logic             pause,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [DUR_W-1:0] elapsed,
  output logic [DUR_W-1:0] remaining
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [DUR_W-1:0]   elapsed_q, elapsed_d;
  logic               done_q, done_d;
  logic [DUR_W-1:0]   elapsed_inc;

  assign elapsed_inc = elapsed_q + DUR_W'(1);

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    dur_d     = dur_q;
    elapsed_d = elapsed_q;
    done_d    = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      pre_d   = '0;
    end else if (start) begin
      pre_d     = '0;
      elapsed_d = '0;
      if (duration == '0) begin
        dur_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        dur_d   = duration;
        state_d = RUN;
      end
    end else if (state_q != IDLE) begin
      if (pause) begin
        state_d = PAUSED;
      end else begin
        // Releasing pause resumes counting immediately, so a pause of P sampled
        // cycles stretches the interval by exactly P cycles.
        state_d = RUN;
        if (pre_q == PRE_LAST) begin
          pre_d     = '0;
          elapsed_d = elapsed_inc;
          if (elapsed_inc == dur_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      dur_q     <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      dur_q     <= dur_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign elapsed   = elapsed_q;
  assign remaining = dur_q - elapsed_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Bench for delay_scheduler: directed scenarios plus random traffic, all checked
// against a model that counts active cycles rather than units.
module tb_delay_scheduler;

  localparam int T     = 4;
  localparam int DUR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DUR_W-1:0] duration = '0;
  logic             pause = 1'b0;
  logic             cancel = 1'b0;
  logic             busy;
  logic             done;
  logic [DUR_W-1:0] elapsed;
  logic [DUR_W-1:0] remaining;

  int tests = 0;
  int fails = 0;

  // Reference model: interval progress measured as active (unpaused) cycles.
  int m_armed = 0;
  int m_dur   = 0;
  int m_act   = 0;
  int m_elap  = 0;
  int m_done  = 0;

  delay_scheduler #(.TICK_CYCLES(T), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .duration(duration),
    .pause(pause), .cancel(cancel), .busy(busy), .done(done),
    .elapsed(elapsed), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int s, input int d, input int p, input int c, input int r);
    m_done = 0;
    if (r != 0) begin
      m_armed = 0; m_dur = 0; m_act = 0; m_elap = 0;
    end else if (c != 0) begin
      m_armed = 0; m_act = 0;
    end else if (s != 0) begin
      m_act = 0; m_elap = 0;
      if (d == 0) begin
        m_done = 1; m_armed = 0; m_dur = 0;
      end else begin
        m_armed = 1; m_dur = d;
      end
    end else if (m_armed != 0 && p == 0) begin
      m_act++;
      m_elap = m_act / T;
      if (m_act == m_dur * T) begin
        m_done = 1; m_armed = 0;
      end
    end
  endtask

  task automatic step(input int s, input int d, input int p, input int c, input int r);
    start = (s != 0); duration = DUR_W'(d); pause = (p != 0); cancel = (c != 0); rst = (r != 0);
    @(posedge clk);
    model_edge(s, d, p, c, r);
    #1;
    chk("busy", int'(busy), m_armed);
    chk("done", int'(done), m_done);
    chk("elapsed", int'(elapsed), m_elap);
    chk("remaining", int'(remaining), m_dur - m_elap);
    start = 1'b0; pause = 1'b0; cancel = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset
    #2;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_elapsed", int'(elapsed), 0);
    chk("rst_remaining", int'(remaining), 0);

    // Basic interval of 3 units: done exactly 12 cycles after start
    step(1, 3, 0, 0, 0);
    chk("basic_busy", int'(busy), 1);
    chk("basic_rem", int'(remaining), 3);
    idle(4);
    chk("basic_el1", int'(elapsed), 1);
    idle(7);
    chk("basic_nodone", int'(done), 0);
    idle(1);
    chk("basic_done", int'(done), 1);
    chk("basic_busy_lo", int'(busy), 0);
    chk("basic_el3", int'(elapsed), 3);
    chk("basic_rem0", int'(remaining), 0);
    idle(1);
    chk("basic_pulse1", int'(done), 0);

    // Zero duration
    step(1, 0, 0, 0, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    idle(1);
    chk("zero_pulse1", int'(done), 0);

    // Pause 5 cycles from cycle 3 of a 2-unit interval: done at cycle 13
    step(1, 2, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    chk("pause_frozen", int'(elapsed), 0);
    idle(5);
    chk("pause_nodone", int'(done), 0);
    idle(1);
    chk("pause_done", int'(done), 1);
    chk("pause_el", int'(elapsed), 2);

    // Restart at cycle 6 with duration 1: single done at cycle 10
    step(1, 5, 0, 0, 0);
    idle(5);
    step(1, 1, 0, 0, 0);
    idle(3);
    chk("restart_nodone", int'(done), 0);
    idle(1);
    chk("restart_done", int'(done), 1);
    chk("restart_el", int'(elapsed), 1);

    // Cancel at cycle 7
    step(1, 5, 0, 0, 0);
    idle(6);
    step(0, 0, 0, 1, 0);
    chk("cancel_busy", int'(busy), 0);
    chk("cancel_el", int'(elapsed), 1);
    chk("cancel_rem", int'(remaining), 4);
    idle(25);
    chk("cancel_nodone", int'(done), 0);

    // Cancel on the final tick
    step(1, 1, 0, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 0);
    chk("fcancel_done", int'(done), 0);
    chk("fcancel_busy", int'(busy), 0);

    // Start on the final tick restarts instead of completing
    step(1, 1, 0, 0, 0);
    idle(3);
    step(1, 2, 0, 0, 0);
    chk("fstart_done", int'(done), 0);
    chk("fstart_busy", int'(busy), 1);
    chk("fstart_rem", int'(remaining), 2);
    idle(8);
    chk("fstart_final", int'(done), 1);

    // Reset mid-interval, then a fresh interval completes
    step(1, 3, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_el", int'(elapsed), 0);
    chk("mrst_rem", int'(remaining), 0);
    chk("mrst_done", int'(done), 0);
    step(1, 2, 0, 0, 0);
    idle(8);
    chk("mrst_after", int'(done), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(15) == 0) ? 1 : 0,
           int'($urandom_range(5)),
           ($urandom_range(3) == 0) ? 1 : 0,
           ($urandom_range(40) == 0) ? 1 : 0,
           ($urandom_range(200) == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
